// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between mem_stage (master) and the data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-stage controller: runs lw/sw through a req/ready handshake and registers the M/W bundle.
// Optional overflow exception writeback is enabled by defining MEM_STAGE_EXCEPTION_EN.
module mem_stage #(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] o_in,
    input  logic [31:0] b_in,
    input  logic [31:0] ins_in,
    input  logic        ovf_in,
    mem_stage_if.master mem,
    output logic        stall,
    output logic [31:0] mw_d,
    output logic [4:0]  mw_rd,
    output logic        mw_we,
    output logic [31:0] mw_ins
);
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    typedef enum logic {IDLE, ACCESS} state_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] d;
    } wb_t;

    state_t      state;
    logic [31:0] acc_ins;
    logic        is_mem;
    wb_t         wb_now;
    wb_t         wb_acc;

    // A zero destination doubles as "no write", which also covers the all-zero bubble.
    function automatic wb_t wb_rules(input logic [31:0] ins, input logic [31:0] result);
        wb_t w;
        w = '0;
        case (ins[31:27])
            OP_RTYPE, OP_ADDI, OP_LW: begin
                w.rd = ins[26:22];
                w.d  = result;
            end
            OP_JAL: begin
                w.rd = 5'd31;
                w.d  = result;
            end
            OP_SETX: begin
                w.rd = 5'd30;
                w.d  = result;
            end
            default: ;
        endcase
        w.we = (w.rd != 5'd0);
        return w;
    endfunction

`ifdef MEM_STAGE_EXCEPTION_EN
    localparam logic [4:0] ALU_ADD = 5'b00000;
    localparam logic [4:0] ALU_SUB = 5'b00001;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_in;
`endif

    always_comb begin
        is_mem = (ins_in[31:27] == OP_LW) || (ins_in[31:27] == OP_SW);
        wb_now = wb_rules(ins_in, o_in);
`ifdef MEM_STAGE_EXCEPTION_EN
        if (ovf_in) begin
            if (ins_in[31:27] == OP_RTYPE && ins_in[6:2] == ALU_ADD)
                wb_now = '{we: 1'b1, rd: 5'd30, d: 32'd1};
            else if (ins_in[31:27] == OP_ADDI)
                wb_now = '{we: 1'b1, rd: 5'd30, d: 32'd2};
            else if (ins_in[31:27] == OP_RTYPE && ins_in[6:2] == ALU_SUB)
                wb_now = '{we: 1'b1, rd: 5'd30, d: 32'd3};
        end
`endif
        wb_acc = wb_rules(acc_ins, mem.mem_rdata);
    end

    // Gated by reset so an abandoned access releases the pipeline immediately.
    assign stall = ~reset & (((state == IDLE) & is_mem) | ((state == ACCESS) & ~mem.mem_ready));

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            acc_ins       <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mw_d          <= '0;
            mw_rd         <= '0;
            mw_we         <= 1'b0;
            mw_ins        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem) begin
                        state         <= ACCESS;
                        acc_ins       <= ins_in;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= (ins_in[31:27] == OP_SW);
                        mem.mem_addr  <= o_in[ADDR_W-1:0];
                        mem.mem_wdata <= b_in;
                        mw_d          <= '0;
                        mw_rd         <= '0;
                        mw_we         <= 1'b0;
                        mw_ins        <= '0;
                    end else begin
                        mw_d   <= wb_now.d;
                        mw_rd  <= wb_now.rd;
                        mw_we  <= wb_now.we;
                        mw_ins <= ins_in;
                    end
                end
                ACCESS: begin
                    if (mem.mem_ready) begin
                        state       <= IDLE;
                        mem.mem_req <= 1'b0;
                        mw_d        <= wb_acc.d;
                        mw_rd       <= wb_acc.rd;
                        mw_we       <= wb_acc.we;
                        mw_ins      <= acc_ins;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations are hand-computed per scenario.
`timescale 1ns/1ps
module tb_mem_stage;
    localparam int ADDR_W = 12;
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;

    logic        clk;
    logic        reset;
    logic [31:0] o_in;
    logic [31:0] b_in;
    logic [31:0] ins_in;
    logic        ovf_in;
    logic        stall;
    logic [31:0] mw_d;
    logic [4:0]  mw_rd;
    logic        mw_we;
    logic [31:0] mw_ins;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if #(.ADDR_W(ADDR_W)) bus ();

    mem_stage #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .o_in   (o_in),
        .b_in   (b_in),
        .ins_in (ins_in),
        .ovf_in (ovf_in),
        .mem    (bus),
        .stall  (stall),
        .mw_d   (mw_d),
        .mw_rd  (mw_rd),
        .mw_we  (mw_we),
        .mw_ins (mw_ins)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_ins(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
        return {op, rd, 15'd0, alu, 2'b00};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] o, input logic [31:0] b, input logic ovf);
        ins_in = ins;
        o_in   = o;
        b_in   = b;
        ovf_in = ovf;
    endtask

    task automatic test_reset();
        logic [31:0] add9;
        add9 = mk_ins(OP_RTYPE, 5'd9, ALU_ADD);
        @(negedge clk);
        drive(add9, 32'h55, 32'h0, 1'b0);
        @(posedge clk); #1;
        n_checks++;
        if ({mw_we, mw_rd, mw_d} !== {1'b1, 5'd9, 32'h55}) begin
            n_fail++; $display("FAIL reset_pre: got %h expected %h", {mw_we, mw_rd, mw_d}, {1'b1, 5'd9, 32'h55});
        end
        drive(32'h0, 32'h0, 32'h0, 1'b0);
        #2; reset = 1'b1; #1;
        n_checks++;
        if ({mw_we, mw_rd, mw_d, mw_ins} !== 70'd0) begin
            n_fail++; $display("FAIL reset_mw: got %h expected 0", {mw_we, mw_rd, mw_d, mw_ins});
        end
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 46'd0) begin
            n_fail++; $display("FAIL reset_bus: got %h expected 0", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata});
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        logic [31:0] add3;
        add3 = mk_ins(OP_RTYPE, 5'd3, ALU_ADD);
        @(negedge clk);
        drive(add3, 32'h10, 32'h0, 1'b0);
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL add_stall: got %b expected 0", stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({mw_we, mw_rd, mw_d} !== {1'b1, 5'd3, 32'h10}) begin
            n_fail++; $display("FAIL add_wb: got %h expected %h", {mw_we, mw_rd, mw_d}, {1'b1, 5'd3, 32'h10});
        end
        n_checks++;
        if (mw_ins !== add3) begin
            n_fail++; $display("FAIL add_ins: got %h expected %h", mw_ins, add3);
        end
        n_checks++;
        if ({bus.mem_req, stall} !== 2'b00) begin
            n_fail++; $display("FAIL add_idle_ready: got req/stall %b expected 00", {bus.mem_req, stall});
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_store();
        logic [31:0] sw4;
        int stall_cycles;
        sw4 = mk_ins(OP_SW, 5'd4, 5'd0);
        stall_cycles = 0;
        @(negedge clk);
        drive(sw4, 32'h40, 32'hDEADBEEF, 1'b0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            bus.mem_ready = (cyc == 3);
            #1;
            if (stall === 1'b1) stall_cycles++;
            if (cyc > 0) begin
                n_checks++;
                if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 12'h040, 32'hDEADBEEF}) begin
                    n_fail++;
                    $display("FAIL sw_bus_cyc%0d: got %h expected %h", cyc,
                             {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 12'h040, 32'hDEADBEEF});
                end
            end
            if (cyc == 1) begin
                n_checks++;
                if ({mw_we, mw_ins} !== 33'd0) begin
                    n_fail++; $display("FAIL sw_bubble: got %h expected 0", {mw_we, mw_ins});
                end
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0);
        #1;
        n_checks++;
        if (stall_cycles != 3) begin
            n_fail++; $display("FAIL sw_stall_cycles: got %0d expected 3", stall_cycles);
        end
        n_checks++;
        if ({bus.mem_req, mw_we} !== 2'b00) begin
            n_fail++; $display("FAIL sw_done: got req/we %b expected 00", {bus.mem_req, mw_we});
        end
        n_checks++;
        if (mw_ins !== sw4) begin
            n_fail++; $display("FAIL sw_ins: got %h expected %h", mw_ins, sw4);
        end
    endtask

    task automatic test_load();
        int stall_cycles;
        stall_cycles = 0;
        @(negedge clk);
        drive(mk_ins(OP_LW, 5'd5, 5'd0), 32'h80, 32'h0, 1'b0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        #1;
        if (stall === 1'b1) stall_cycles++;
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL lw_req_early: got %b expected 0", bus.mem_req);
        end
        @(posedge clk); #1;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h00001234;
        #1;
        if (stall === 1'b1) stall_cycles++;
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 12'h080}) begin
            n_fail++; $display("FAIL lw_bus: got %h expected %h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 12'h080});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({mw_we, mw_rd, mw_d} !== {1'b1, 5'd5, 32'h1234}) begin
            n_fail++; $display("FAIL lw_wb: got %h expected %h", {mw_we, mw_rd, mw_d}, {1'b1, 5'd5, 32'h1234});
        end
        n_checks++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL lw_req_clear: got %b expected 0", bus.mem_req);
        end
        n_checks++;
        if (stall_cycles != 1) begin
            n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 1", stall_cycles);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_overflow();
        logic [31:0] t_ins [4];
        logic [31:0] t_o   [4];
        logic [4:0]  t_rd  [4];
        logic [31:0] t_d   [4];
        t_ins[0] = mk_ins(OP_RTYPE, 5'd7, ALU_SUB); t_o[0] = 32'h8000_0001;
        t_ins[1] = mk_ins(OP_RTYPE, 5'd4, ALU_ADD); t_o[1] = 32'h7FFF_FFFF;
        t_ins[2] = mk_ins(OP_ADDI,  5'd6, 5'd0);    t_o[2] = 32'h0000_1234;
        t_ins[3] = mk_ins(OP_JAL,   5'd0, 5'd0);    t_o[3] = 32'h0000_0021;
`ifdef MEM_STAGE_EXCEPTION_EN
        t_rd[0] = 5'd30; t_d[0] = 32'd3;
        t_rd[1] = 5'd30; t_d[1] = 32'd1;
        t_rd[2] = 5'd30; t_d[2] = 32'd2;
`else
        t_rd[0] = 5'd7;  t_d[0] = 32'h8000_0001;
        t_rd[1] = 5'd4;  t_d[1] = 32'h7FFF_FFFF;
        t_rd[2] = 5'd6;  t_d[2] = 32'h0000_1234;
`endif
        t_rd[3] = 5'd31; t_d[3] = 32'h0000_0021;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(t_ins[i], t_o[i], 32'h0, 1'b1);
            @(posedge clk); #1;
            n_checks++;
            if ({mw_we, mw_rd, mw_d} !== {1'b1, t_rd[i], t_d[i]}) begin
                n_fail++; $display("FAIL ovf_%0d: got %h expected %h", i, {mw_we, mw_rd, mw_d}, {1'b1, t_rd[i], t_d[i]});
            end
        end
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_writeback_rules();
        logic [31:0] t_ins [4];
        logic [31:0] t_o   [4];
        logic        t_we  [4];
        logic [4:0]  t_rd  [4];
        t_ins[0] = mk_ins(OP_RTYPE,  5'd0,  ALU_ADD); t_o[0] = 32'h99; t_we[0] = 1'b0; t_rd[0] = 5'd0;
        t_ins[1] = mk_ins(OP_JAL,    5'd12, 5'd0);    t_o[1] = 32'h2A; t_we[1] = 1'b1; t_rd[1] = 5'd31;
        t_ins[2] = mk_ins(OP_SETX,   5'd0,  5'd0);    t_o[2] = 32'h07; t_we[2] = 1'b1; t_rd[2] = 5'd30;
        t_ins[3] = mk_ins(5'b11111,  5'd9,  5'd0);    t_o[3] = 32'h5A; t_we[3] = 1'b0; t_rd[3] = 5'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(t_ins[i], t_o[i], 32'h0, 1'b0);
            @(posedge clk); #1;
            n_checks++;
            if ({mw_we, mw_rd} !== {t_we[i], t_rd[i]}) begin
                n_fail++; $display("FAIL wb_rule_%0d: got we/rd %h expected %h", i, {mw_we, mw_rd}, {t_we[i], t_rd[i]});
            end
            if (t_we[i]) begin
                n_checks++;
                if (mw_d !== t_o[i]) begin
                    n_fail++; $display("FAIL wb_data_%0d: got %h expected %h", i, mw_d, t_o[i]);
                end
            end
        end
        @(negedge clk);
        drive(32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(mk_ins(OP_LW, 5'd8, 5'd0), 32'h100, 32'h0, 1'b0);
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000BEEF;
        @(posedge clk); #1;
        n_checks++;
        if ({mw_we, mw_rd, mw_d} !== {1'b1, 5'd8, 32'hBEEF}) begin
            n_fail++; $display("FAIL b2b_lw: got %h expected %h", {mw_we, mw_rd, mw_d}, {1'b1, 5'd8, 32'hBEEF});
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        drive(mk_ins(OP_SW, 5'd0, 5'd0), 32'h101, 32'hA5A5A5A5, 1'b0);
        #1;
        n_checks++;
        if ({bus.mem_req, stall} !== 2'b01) begin
            n_fail++; $display("FAIL b2b_gap: got req/stall %b expected 01", {bus.mem_req, stall});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 12'h101, 32'hA5A5A5A5}) begin
            n_fail++;
            $display("FAIL b2b_sw_bus: got %h expected %h",
                     {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, 1'b1, 12'h101, 32'hA5A5A5A5});
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++; $display("FAIL b2b_sw_stall: got %b expected 0", stall);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.mem_req, mw_we} !== 2'b00) begin
            n_fail++; $display("FAIL b2b_sw_done: got req/we %b expected 00", {bus.mem_req, mw_we});
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_access();
        @(negedge clk);
        drive(mk_ins(OP_LW, 5'd5, 5'd0), 32'h0AB, 32'h0, 1'b0);
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (bus.mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rst_acc_pre: got req %b expected 1", bus.mem_req);
        end
        #2; reset = 1'b1; #1;
        n_checks++;
        if ({bus.mem_req, stall} !== 2'b00) begin
            n_fail++; $display("FAIL rst_acc_drop: got req/stall %b expected 00", {bus.mem_req, stall});
        end
        @(negedge clk);
        reset = 1'b0;
        drive(mk_ins(OP_LW, 5'd12, 5'd0), 32'h03C, 32'h0, 1'b0);
        #1;
        n_checks++;
        if ({bus.mem_req, stall} !== 2'b01) begin
            n_fail++; $display("FAIL rst_acc_idle: got req/stall %b expected 01", {bus.mem_req, stall});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 12'h03C}) begin
            n_fail++; $display("FAIL rst_acc_req: got %h expected %h", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 12'h03C});
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE0001;
        @(posedge clk); #1;
        n_checks++;
        if ({mw_we, mw_rd, mw_d} !== {1'b1, 5'd12, 32'hCAFE0001}) begin
            n_fail++; $display("FAIL rst_acc_lw: got %h expected %h", {mw_we, mw_rd, mw_d}, {1'b1, 5'd12, 32'hCAFE0001});
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 1'b0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_add();
        test_store();
        test_load();
        test_overflow();
        test_writeback_rules();
        test_back_to_back();
        test_reset_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
